// File: rtl/addr_mode_sequencer.sv
// Per-instruction timing controller: FETCH -> DECODE -> ADDR -> EXEC, with
// addressing sub-state counting, IND_Y carry capture, rdy stall and illegal-mode halt.
module addr_mode_sequencer #(
  parameter int NUM_MODES = 10,
  parameter int MAX_EXEC  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] opcode_in,
  input  logic [3:0] addr_mode,
  input  logic [1:0] exec_cycles,
  input  logic       page_cross,
  output logic [7:0] opcode_reg,
  output logic [2:0] phase,
  output logic [1:0] mode_state,
  output logic [3:0] mode_reg,
  output logic [1:0] exec_state,
  output logic       sync,
  output logic       carry_to_high,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    ADDR   = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } phase_e;

  localparam logic [3:0] IndYMode = 4'd9;
  localparam logic [1:0] MaxExecL = 2'(MAX_EXEC);

  phase_e     phase_q, phase_d;
  logic [7:0] opcodeReg_q, opcodeReg_d;
  logic [3:0] modeReg_q, modeReg_d;
  logic [1:0] modeState_q, modeState_d;
  logic [1:0] execState_q, execState_d;
  logic [1:0] execLen_q, execLen_d;
  logic       carryToHigh_q, carryToHigh_d;
  logic       illegal_q, illegal_d;

  logic       lastAddr;
  logic       lastExec;
  logic       decodeIllegal;
  logic [2:0] decodeCount;

  // Number of address cycles each legal mode spends in ADDR.
  function automatic logic [2:0] addrCount(input logic [3:0] m);
    case (m)
      4'd0, 4'd1:       addrCount = 3'd0;
      4'd2:             addrCount = 3'd1;
      4'd3, 4'd4, 4'd5: addrCount = 3'd2;
      4'd6, 4'd7:       addrCount = 3'd3;
      4'd8, 4'd9:       addrCount = 3'd4;
      default:          addrCount = 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= FETCH;
      opcodeReg_q   <= 8'h00;
      modeReg_q     <= 4'd0;
      modeState_q   <= 2'd0;
      execState_q   <= 2'd0;
      execLen_q     <= 2'd1;
      carryToHigh_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      opcodeReg_q   <= opcodeReg_d;
      modeReg_q     <= modeReg_d;
      modeState_q   <= modeState_d;
      execState_q   <= execState_d;
      execLen_q     <= execLen_d;
      carryToHigh_q <= carryToHigh_d;
      illegal_q     <= illegal_d;
    end
  end

  always_comb begin
    decodeIllegal = int'(addr_mode) >= NUM_MODES;
    decodeCount   = addrCount(addr_mode);
    lastAddr      = ({1'b0, modeState_q} == (addrCount(modeReg_q) - 3'd1));
    lastExec      = (execState_q == (execLen_q - 2'd1));

    phase_d       = phase_q;
    opcodeReg_d   = opcodeReg_q;
    modeReg_d     = modeReg_q;
    modeState_d   = modeState_q;
    execState_d   = execState_q;
    execLen_d     = execLen_q;
    carryToHigh_d = carryToHigh_q;
    illegal_d     = illegal_q;

    // With rdy low nothing advances; HALT only leaves through rst.
    if (rdy) begin
      case (phase_q)
        FETCH: begin
          opcodeReg_d   = opcode_in;
          carryToHigh_d = 1'b0;
          phase_d       = DECODE;
        end
        DECODE: begin
          modeReg_d = addr_mode;
          if (exec_cycles == 2'd0)
            execLen_d = 2'd1;
          else if (int'(exec_cycles) > MAX_EXEC)
            execLen_d = MaxExecL;
          else
            execLen_d = exec_cycles;
          if (decodeIllegal) begin
            phase_d   = HALT;
            illegal_d = 1'b1;
          end else if (decodeCount == 3'd0) begin
            phase_d     = EXEC;
            execState_d = 2'd0;
          end else begin
            phase_d     = ADDR;
            modeState_d = 2'd0;
          end
        end
        ADDR: begin
          // IND_Y low-byte carry is captured at the end of A1 and of A2.
          if (modeReg_q == IndYMode && (modeState_q == 2'd1 || modeState_q == 2'd2))
            carryToHigh_d = page_cross;
          if (lastAddr) begin
            phase_d     = EXEC;
            execState_d = 2'd0;
            modeState_d = 2'd0;
          end else begin
            modeState_d = modeState_q + 2'd1;
          end
        end
        EXEC: begin
          if (lastExec) begin
            phase_d     = FETCH;
            execState_d = 2'd0;
          end else begin
            execState_d = execState_q + 2'd1;
          end
        end
        HALT: begin
          phase_d = HALT;
        end
        default: begin
          phase_d = FETCH;
        end
      endcase
    end
  end

  always_comb begin
    phase         = phase_q;
    opcode_reg    = opcodeReg_q;
    mode_reg      = modeReg_q;
    mode_state    = modeState_q;
    exec_state    = execState_q;
    carry_to_high = carryToHigh_q;
    illegal       = illegal_q;
    sync          = (phase_q == FETCH);
    instr_done    = (phase_q == EXEC) && lastExec && rdy && !rst;
  end

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// Bench for addr_mode_sequencer: directed vector table, hand-written halt/abort
// sequences, then randomized stimulus against a position-in-instruction model.
module tb_addr_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst, rdy, page_cross;
  logic [7:0] opcode_in;
  logic [3:0] addr_mode;
  logic [1:0] exec_cycles;
  logic [7:0] opcode_reg;
  logic [2:0] phase;
  logic [1:0] mode_state, exec_state;
  logic [3:0] mode_reg;
  logic       sync, carry_to_high, instr_done, illegal;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  addr_mode_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .opcode_in    (opcode_in),
    .addr_mode    (addr_mode),
    .exec_cycles  (exec_cycles),
    .page_cross   (page_cross),
    .opcode_reg   (opcode_reg),
    .phase        (phase),
    .mode_state   (mode_state),
    .mode_reg     (mode_reg),
    .exec_state   (exec_state),
    .sync         (sync),
    .carry_to_high(carry_to_high),
    .instr_done   (instr_done),
    .illegal      (illegal)
  );

  // Expected bundle layout: {phase, mode_state, exec_state, done, carry, sync, opcode_reg, illegal}
  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [7:0]  op;
    logic [3:0]  mode;
    logic [1:0]  ex;
    logic        pc;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] bundle(input logic [2:0] ph, input logic [1:0] ms,
                                         input logic [1:0] es, input logic done,
                                         input logic carry, input logic sy,
                                         input logic [7:0] opr, input logic ill);
    return {ph, ms, es, done, carry, sy, opr, ill};
  endfunction

  function automatic vec_t mk(input logic r, input logic rd, input logic [7:0] op,
                              input logic [3:0] m, input logic [1:0] ex, input logic pc,
                              input logic [2:0] ph, input logic [1:0] ms, input logic [1:0] es,
                              input logic done, input logic carry, input logic sy,
                              input logic [7:0] opr, input logic ill);
    vec_t v;
    v.rst  = r;
    v.rdy  = rd;
    v.op   = op;
    v.mode = m;
    v.ex   = ex;
    v.pc   = pc;
    v.exp  = bundle(ph, ms, es, done, carry, sy, opr, ill);
    return v;
  endfunction

  function automatic logic [18:0] dutBundle();
    return {phase, mode_state, exec_state, instr_done, carry_to_high, sync, opcode_reg, illegal};
  endfunction

  // Reference model: position within the current instruction plus latched fields.
  int         mPos;
  int         mLen;
  logic [7:0] mOp;
  logic [3:0] mMode;
  logic       mCarry;
  logic       mIll;

  function automatic int cnt(input logic [3:0] m);
    int table_c[10] = '{0, 0, 1, 2, 2, 2, 3, 3, 4, 4};
    return (m < 10) ? table_c[m] : 0;
  endfunction

  function automatic logic [18:0] modelBundle();
    logic [2:0] ph;
    logic [1:0] ms, es;
    logic       done, sy;
    ph = 3'd0; ms = 2'd0; es = 2'd0; done = 1'b0; sy = 1'b0;
    if (mIll) begin
      ph = 3'd4;
    end else if (mPos == 0) begin
      ph = 3'd0;
      sy = 1'b1;
    end else if (mPos == 1) begin
      ph = 3'd1;
    end else if (mPos < 2 + cnt(mMode)) begin
      ph = 3'd2;
      ms = 2'(mPos - 2);
    end else begin
      ph = 3'd3;
      es = 2'(mPos - 2 - cnt(mMode));
      done = rdy && !rst && (mPos - 2 - cnt(mMode) == mLen - 1);
    end
    return {ph, ms, es, done, mCarry, sy, mOp, mIll};
  endfunction

  task automatic modelStep();
    if (rst) begin
      mPos = 0; mLen = 1; mOp = 8'h00; mMode = 4'd0; mCarry = 1'b0; mIll = 1'b0;
    end else if (rdy && !mIll) begin
      if (mPos == 0) begin
        mOp = opcode_in;
        mCarry = 1'b0;
        mPos = 1;
      end else if (mPos == 1) begin
        mMode = addr_mode;
        mLen  = (exec_cycles == 2'd0) ? 1 : int'(exec_cycles);
        if (addr_mode >= 4'd10) mIll = 1'b1;
        else mPos = 2;
      end else begin
        if (mMode == 4'd9 && (mPos == 3 || mPos == 4)) mCarry = page_cross;
        if (mPos == 1 + cnt(mMode) + mLen) mPos = 0;
        else mPos = mPos + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [7:0] op,
                               input logic [3:0] m, input logic [1:0] ex, input logic pc);
    @(negedge clk);
    rst = r; rdy = rd; opcode_in = op; addr_mode = m; exec_cycles = ex; page_cross = pc;
    #1;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    modelStep();
  endtask

  task automatic checkOutput(input string name, input logic [22:0] got, input logic [22:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; opcode_in = 8'h00; addr_mode = 4'd0; exec_cycles = 2'd0; page_cross = 1'b0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 4'd0, 2'd0, 1'b0);
      finishCycle();
    end

    // IMM, exec 1
    vecs.push_back(mk(0,1,8'hA9,0,1,0, 0,0,0,0,0,1,8'h00,0));
    vecs.push_back(mk(0,1,8'h00,0,1,0, 1,0,0,0,0,0,8'hA9,0));
    vecs.push_back(mk(0,1,8'h00,0,1,0, 3,0,0,1,0,0,8'hA9,0));
    // IND_X, exec 2
    vecs.push_back(mk(0,1,8'hA1,0,0,0, 0,0,0,0,0,1,8'hA9,0));
    vecs.push_back(mk(0,1,8'h00,8,2,0, 1,0,0,0,0,0,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,0,0,0,0,0,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,1,0,0,0,0,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,2,0,0,0,0,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,3,0,0,0,0,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 3,0,0,0,0,0,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 3,0,1,1,0,0,8'hA1,0));
    // IND_Y, carry only in A1
    vecs.push_back(mk(0,1,8'hB1,0,0,0, 0,0,0,0,0,1,8'hA1,0));
    vecs.push_back(mk(0,1,8'h00,9,1,0, 1,0,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,0,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,1, 2,1,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,2,0,0,1,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,3,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 3,0,0,1,0,0,8'hB1,0));
    // IND_Y, carry only in A2 (A0 carry ignored), survives into FETCH
    vecs.push_back(mk(0,1,8'hB1,0,0,0, 0,0,0,0,0,1,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,9,1,0, 1,0,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,1, 2,0,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,1,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,1, 2,2,0,0,0,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,3,0,0,1,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 3,0,0,1,1,0,8'hB1,0));
    vecs.push_back(mk(0,1,8'hEA,0,0,0, 0,0,0,0,1,1,8'hB1,0));
    // IMPL with exec_cycles 0 behaves as 1
    vecs.push_back(mk(0,1,8'h00,1,0,0, 1,0,0,0,0,0,8'hEA,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 3,0,0,1,0,0,8'hEA,0));
    // ABS, exec 3, stalled 3 cycles in A1
    vecs.push_back(mk(0,1,8'hAD,0,0,0, 0,0,0,0,0,1,8'hEA,0));
    vecs.push_back(mk(0,1,8'h00,5,3,0, 1,0,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,0,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 2,1,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 2,1,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 2,1,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 2,1,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,1,8'h00,0,1,0, 3,0,0,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,1,8'h00,0,1,0, 3,0,1,0,0,0,8'hAD,0));
    vecs.push_back(mk(0,1,8'h00,0,1,0, 3,0,2,1,0,0,8'hAD,0));
    // IMM with a stall on its only EXEC cycle
    vecs.push_back(mk(0,1,8'h4C,0,0,0, 0,0,0,0,0,1,8'hAD,0));
    vecs.push_back(mk(0,1,8'h00,0,1,0, 1,0,0,0,0,0,8'h4C,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 3,0,0,0,0,0,8'h4C,0));
    vecs.push_back(mk(0,1,8'h00,0,0,0, 3,0,0,1,0,0,8'h4C,0));
    // Illegal mode 12
    vecs.push_back(mk(0,1,8'h02,0,0,0, 0,0,0,0,0,1,8'h4C,0));
    vecs.push_back(mk(0,1,8'h00,12,2,0, 1,0,0,0,0,0,8'h02,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].op, vecs[i].mode, vecs[i].ex, vecs[i].pc);
      checkOutput($sformatf("vec%0d", i), {dutBundle(), 4'h0}, {vecs[i].exp, 4'h0});
      finishCycle();
    end

    // HALT holds regardless of rdy and inputs
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'(i % 2), 8'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      checkOutput($sformatf("halt%0d", i), {dutBundle(), mode_reg},
                  {bundle(3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1), 4'd12});
      finishCycle();
    end
    applyStimulus(1'b1, 1'b1, 8'h00, 4'd0, 2'd0, 1'b0);
    checkOutput("halt_rst", {dutBundle(), 4'h0}, {bundle(3'd4, 0, 0, 0, 0, 0, 8'h02, 1), 4'h0});
    finishCycle();

    // Reset aborting a 3-cycle execute in exec state 1
    applyStimulus(1'b0, 1'b1, 8'hEA, 4'd0, 2'd0, 1'b0);
    checkOutput("post_halt_fetch", {dutBundle(), 4'h0}, {bundle(3'd0, 0, 0, 0, 0, 1, 8'h00, 0), 4'h0});
    finishCycle();
    applyStimulus(1'b0, 1'b1, 8'h00, 4'd1, 2'd3, 1'b0);
    checkOutput("abort_dec", {dutBundle(), 4'h0}, {bundle(3'd1, 0, 0, 0, 0, 0, 8'hEA, 0), 4'h0});
    finishCycle();
    applyStimulus(1'b0, 1'b1, 8'h00, 4'd0, 2'd0, 1'b0);
    checkOutput("abort_e0", {dutBundle(), 4'h0}, {bundle(3'd3, 0, 0, 0, 0, 0, 8'hEA, 0), 4'h0});
    finishCycle();
    applyStimulus(1'b1, 1'b1, 8'h00, 4'd0, 2'd0, 1'b0);
    checkOutput("abort_e1", {dutBundle(), 4'h0}, {bundle(3'd3, 0, 1, 0, 0, 0, 8'hEA, 0), 4'h0});
    finishCycle();
    applyStimulus(1'b0, 1'b1, 8'h11, 4'd0, 2'd1, 1'b0);
    checkOutput("abort_fetch", {dutBundle(), 4'h0}, {bundle(3'd0, 0, 0, 0, 0, 1, 8'h00, 0), 4'h0});
    finishCycle();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 9) < 8),
                    8'($urandom),
                    ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                    2'($urandom),
                    1'($urandom));
      checkOutput($sformatf("rand%0d", i), {dutBundle(), mode_reg}, {modelBundle(), mMode});
      finishCycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
